// File: rtl/cmp_unit.sv
// Multi-cycle integer relational comparator for i32/i64 Wasm ops.
// Operands are left-aligned and compared CHUNK bits per cycle, MSB chunk first.
module cmp_unit #(
    parameter int         WIDTH       = 64,
    parameter int         NARROW      = 32,
    parameter int         CHUNK       = 16,
    parameter bit         EARLY_EXIT  = 1'b0,
    parameter logic [2:0] TRAP_BAD_OP = 3'd4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             is64,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       trap
);

    localparam int NCH_WIDE   = WIDTH / CHUNK;
    localparam int NCH_NARROW = NARROW / CHUNK;
    localparam int IDX_W      = (NCH_WIDE > 1) ? $clog2(NCH_WIDE) : 1;
    localparam logic [IDX_W-1:0] TOP_WIDE   = IDX_W'(NCH_WIDE - 1);
    localparam logic [IDX_W-1:0] TOP_NARROW = IDX_W'(NCH_NARROW - 1);

    localparam logic [3:0] OP_EQZ  = 4'd0;
    localparam logic [3:0] OP_EQ   = 4'd1;
    localparam logic [3:0] OP_NE   = 4'd2;
    localparam logic [3:0] OP_LT_S = 4'd3;
    localparam logic [3:0] OP_LT_U = 4'd4;
    localparam logic [3:0] OP_GT_S = 4'd5;
    localparam logic [3:0] OP_GT_U = 4'd6;
    localparam logic [3:0] OP_LE_S = 4'd7;
    localparam logic [3:0] OP_LE_U = 4'd8;
    localparam logic [3:0] OP_GE_S = 4'd9;
    localparam logic [3:0] OP_GE_U = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    logic             res_q, res_d;
    logic [2:0]       trap_q, trap_d;

    function automatic logic is_signed_op(input logic [3:0] o);
        return o inside {OP_LT_S, OP_GT_S, OP_LE_S, OP_GE_S};
    endfunction

    // Narrow operands are shifted to the top so the MSB chunk is always at WIDTH-1;
    // flipping the sign bit turns a signed compare into an unsigned one.
    function automatic logic [WIDTH-1:0] align_op(input logic [WIDTH-1:0] v,
                                                  input logic wide, input logic sgn);
        logic [WIDTH-1:0] t;
        t = wide ? v : (WIDTH'(v[NARROW-1:0]) << (WIDTH - NARROW));
        if (sgn) t[WIDTH-1] = ~t[WIDTH-1];
        return t;
    endfunction

    function automatic logic final_bool(input logic [3:0] o, input logic eq,
                                        input logic lt, input logic gt);
        case (o)
            OP_EQZ, OP_EQ:    return eq;
            OP_NE:            return !eq;
            OP_LT_S, OP_LT_U: return lt;
            OP_GT_S, OP_GT_U: return gt;
            OP_LE_S, OP_LE_U: return lt | eq;
            OP_GE_S, OP_GE_U: return gt | eq;
            default:          return 1'b0;
        endcase
    endfunction

    logic [CHUNK-1:0] a_top, b_top;
    logic             eq_n, lt_n, gt_n, last_chunk;

    assign a_top      = a_q[WIDTH-1 -: CHUNK];
    assign b_top      = b_q[WIDTH-1 -: CHUNK];
    assign eq_n       = eq_q && (a_top == b_top);
    assign lt_n       = lt_q || (eq_q && (a_top < b_top));
    assign gt_n       = gt_q || (eq_q && (a_top > b_top));
    assign last_chunk = (idx_q == '0) || (EARLY_EXIT && !eq_n);

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        res_d   = res_q;
        trap_d  = trap_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d = op;
                    a_d  = align_op(lhs, is64, is_signed_op(op));
                    b_d  = (op == OP_EQZ) ? '0 : align_op(rhs, is64, is_signed_op(op));
                    eq_d = 1'b1;
                    lt_d = 1'b0;
                    gt_d = 1'b0;
                    if (op <= OP_GE_U) begin
                        idx_d   = is64 ? TOP_WIDE : TOP_NARROW;
                        trap_d  = 3'd0;
                        state_d = S_CMP;
                    end else begin
                        res_d   = 1'b0;
                        trap_d  = TRAP_BAD_OP;
                        state_d = S_DONE;
                    end
                end
            end
            S_CMP: begin
                eq_d  = eq_n;
                lt_d  = lt_n;
                gt_d  = gt_n;
                a_d   = a_q << CHUNK;
                b_d   = b_q << CHUNK;
                idx_d = idx_q - 1'b1;
                if (last_chunk) begin
                    res_d   = final_bool(op_q, eq_n, lt_n, gt_n);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            res_q   <= 1'b0;
            trap_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            res_q   <= res_d;
            trap_q  <= trap_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = {{(WIDTH-1){1'b0}}, res_q};
    assign trap      = trap_q;

endmodule

// File: tb/tb_cmp_unit.sv
// Bench for cmp_unit: directed vector table, handshake/reset sequences, and
// randomized ops checked against an arithmetic reference model.
module tb_cmp_unit;

    localparam int TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  in_valid_v;
    logic [1:0]  in_ready_v;
    logic [1:0]  out_valid_v;
    logic [3:0]  op_s;
    logic        is64_s;
    logic [63:0] lhs_s, rhs_s;
    logic        out_ready_s;
    logic [63:0] result_v [2];
    logic [2:0]  trap_v [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cmp_unit u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .op(op_s), .is64(is64_s), .lhs(lhs_s), .rhs(rhs_s),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_s),
        .result(result_v[0]), .trap(trap_v[0])
    );

    cmp_unit #(.EARLY_EXIT(1'b1)) u_early (
        .clk(clk), .reset(reset), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .op(op_s), .is64(is64_s), .lhs(lhs_s), .rhs(rhs_s),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_s),
        .result(result_v[1]), .trap(trap_v[1])
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain Wasm semantics on sign/zero-extended values.
    function automatic void model(input logic [3:0] o, input logic w, input logic [63:0] l,
                                  input logic [63:0] r, input bit early,
                                  output logic [63:0] res, output logic [2:0] tr, output int lat);
        longint      sa, sb;
        logic [63:0] ua, ub, x;
        logic        b;
        int          full, msb;
        if (o > 4'd10) begin
            res = '0; tr = 3'd4; lat = 0;
            return;
        end
        ua = w ? l : {32'b0, l[31:0]};
        ub = (o == 4'd0) ? 64'd0 : (w ? r : {32'b0, r[31:0]});
        sa = w ? $signed(l) : longint'($signed(l[31:0]));
        sb = w ? $signed(r) : longint'($signed(r[31:0]));
        case (o)
            4'd0, 4'd1: b = (ua == ub);
            4'd2:       b = (ua != ub);
            4'd3:       b = (sa < sb);
            4'd4:       b = (ua < ub);
            4'd5:       b = (sa > sb);
            4'd6:       b = (ua > ub);
            4'd7:       b = (sa <= sb);
            4'd8:       b = (ua <= ub);
            4'd9:       b = (sa >= sb);
            default:    b = (ua >= ub);
        endcase
        res  = {63'b0, b};
        tr   = 3'd0;
        full = w ? 4 : 2;
        lat  = full;
        if (early) begin
            x = ua ^ ub;
            if (x != 64'd0) begin
                msb = 63;
                while (!x[msb]) msb--;
                lat = full - msb / 16;
            end
        end
    endfunction

    // Called at a negedge; returns at a negedge after the handshake (if out_ready_s).
    task automatic run_op(input int d, input logic [3:0] o, input logic w,
                          input logic [63:0] l, input logic [63:0] r,
                          output logic [63:0] res, output logic [2:0] tr, output int lat);
        int n;
        op_s = o; is64_s = w; lhs_s = l; rhs_s = r;
        n = 0;
        while (!in_ready_v[d] && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_v[d]) check("accept_timeout", 64'(in_ready_v[d]), 64'd1);
        in_valid_v[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[d] = 1'b0;
        lat = 0;
        while (!out_valid_v[d] && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        res = result_v[d];
        tr  = trap_v[d];
        if (out_ready_s) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        w;
        logic [63:0] l;
        logic [63:0] r;
        logic        res;
        logic [2:0]  tr;
        int          lat;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [63:0] res, held, l, r;
        logic [2:0]  tr, etr;
        logic [63:0] eres;
        int          lat, elat, n;
        logic [3:0]  o;
        logic        w;
        bit          saw;

        vecs[0]  = '{4'd1,  1'b1, 64'h0, 64'h0, 1'b1, 3'd0, 4};
        vecs[1]  = '{4'd1,  1'b1, 64'h0, 64'h1, 1'b0, 3'd0, 4};
        vecs[2]  = '{4'd3,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 3'd0, 4};
        vecs[3]  = '{4'd4,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 3'd0, 4};
        vecs[4]  = '{4'd9,  1'b1, 64'h5, 64'h5, 1'b1, 3'd0, 4};
        vecs[5]  = '{4'd6,  1'b0, 64'hDEAD_BEEF_0000_0002, 64'h1, 1'b1, 3'd0, 2};
        vecs[6]  = '{4'd0,  1'b0, 64'h1_0000_0000, 64'h55, 1'b1, 3'd0, 2};
        vecs[7]  = '{4'd5,  1'b0, 64'h8000_0000, 64'h7FFF_FFFF, 1'b0, 3'd0, 2};
        vecs[8]  = '{4'd8,  1'b0, 64'hFFFF_FFFF, 64'h0, 1'b0, 3'd0, 2};
        vecs[9]  = '{4'd2,  1'b1, 64'h1234, 64'h1234, 1'b0, 3'd0, 4};
        vecs[10] = '{4'd15, 1'b1, 64'h7, 64'h3, 1'b0, 3'd4, 0};
        vecs[11] = '{4'd7,  1'b1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 3'd0, 4};
        vecs[12] = '{4'd10, 1'b0, 64'hFFFF_FFFF_0000_0000, 64'h1, 1'b0, 3'd0, 2};
        vecs[13] = '{4'd11, 1'b0, 64'h1, 64'h1, 1'b0, 3'd4, 0};
        vecs[14] = '{4'd0,  1'b1, 64'h0, 64'hFF, 1'b1, 3'd0, 4};
        vecs[15] = '{4'd2,  1'b1, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 3'd0, 4};

        reset = 1'b1; in_valid_v = '0; out_ready_s = 1'b1;
        op_s = '0; is64_s = 1'b0; lhs_s = '0; rhs_s = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid_v[0]), 64'd0);
        check("rst_result", result_v[0], 64'd0);
        check("rst_trap", 64'(trap_v[0]), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready_v[0]), 64'd1);

        foreach (vecs[i]) begin
            run_op(0, vecs[i].op, vecs[i].w, vecs[i].l, vecs[i].r, res, tr, lat);
            check($sformatf("vec%0d_result", i), res, {63'b0, vecs[i].res});
            check($sformatf("vec%0d_trap", i), 64'(tr), 64'(vecs[i].tr));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d_idle", i), 64'(in_ready_v[0]), 64'd1);
        end

        // Early exit: first chunk differs, so a single CMP cycle.
        run_op(1, 4'd2, 1'b1, 64'h8000_0000_0000_0000, 64'h0, res, tr, lat);
        check("early_ne_result", res, 64'd1);
        check("early_ne_latency", 64'(lat), 64'd1);
        run_op(1, 4'd4, 1'b1, 64'h5, 64'h5, res, tr, lat);
        check("early_equal_latency", 64'(lat), 64'd4);

        // Backpressure: result held while out_ready is low; queued op waits.
        out_ready_s = 1'b0;
        run_op(0, 4'd4, 1'b1, 64'h3, 64'h7, held, tr, lat);
        check("bp_first_result", held, 64'd1);
        op_s = 4'd1; is64_s = 1'b1; lhs_s = 64'h9; rhs_s = 64'h9;
        in_valid_v[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_valid%0d", k), 64'(out_valid_v[0]), 64'd1);
            check($sformatf("bp_result%0d", k), result_v[0], held);
            check($sformatf("bp_trap%0d", k), 64'(trap_v[0]), 64'd0);
            check($sformatf("bp_in_ready%0d", k), 64'(in_ready_v[0]), 64'd0);
        end
        out_ready_s = 1'b1;
        @(negedge clk);
        check("bp_after_hs_valid", 64'(out_valid_v[0]), 64'd0);
        check("bp_after_hs_ready", 64'(in_ready_v[0]), 64'd1);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        check("bp_second_accepted", 64'(in_ready_v[0]), 64'd0);
        lat = 0;
        while (!out_valid_v[0] && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        check("bp_second_latency", 64'(lat), 64'd4);
        check("bp_second_result", result_v[0], 64'd1);
        @(negedge clk);

        // Reset during CMP discards the operation.
        op_s = 4'd1; is64_s = 1'b1; lhs_s = 64'h0; rhs_s = 64'h0;
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid_v[0]), 64'd0);
        check("midrst_in_ready", 64'(in_ready_v[0]), 64'd1);
        check("midrst_result", result_v[0], 64'd0);
        saw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid_v[0]) saw = 1'b1;
        end
        check("midrst_no_output", 64'(saw), 64'd0);

        // Randomized ops on both instances against the model.
        for (int i = 0; i < 240; i++) begin
            int d;
            d = (i % 3 == 2) ? 1 : 0;
            o = 4'($urandom_range(0, 12));
            w = 1'($urandom_range(0, 1));
            l = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: r = l;
                1: r = l ^ (64'h1 << $urandom_range(0, 63));
                2: begin l = 64'(l[15:0]); r = 64'($urandom_range(0, 65535)); end
                3: begin l = l & 64'hFFFF_FFFF_0000_0000; r = {$urandom, $urandom}; end
                default: r = {$urandom, $urandom};
            endcase
            model(o, w, l, r, (d == 1), eres, etr, elat);
            run_op(d, o, w, l, r, res, tr, lat);
            check($sformatf("rand%0d_result op=%0d w=%0d", i, o, w), res, eres);
            check($sformatf("rand%0d_trap", i), 64'(tr), 64'(etr));
            check($sformatf("rand%0d_latency dut=%0d", i, d), 64'(lat), 64'(elat));
        end

        n = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
